registers: RTL and testbench
============================

# registers

Parameterised parallel-load / shift register with a combinational next-state output, used as a datapath storage element in the MIPS design. Each clock edge either captures the parallel input or shifts the stored word left by one bit. The next-state value is exported combinationally so downstream logic can look one cycle ahead.

## Interface

Clocking is fixed as one clock; reset is synchronous and active-low.

Parameters:
- `WIDTH`, default 4: data width in bits; legal range 2..32.

Ports:
- `CLK` input 1: the single clock; all state updates on the rising edge.
- `RST_N` input 1: synchronous reset, active-low; sampled only on the rising edge of `CLK`.
- `D` input WIDTH: parallel load data.
- `sh` input 1: mode select; 0 = parallel load, 1 = shift.
- `Q` output WIDTH: registered contents.
- `Q_next` output WIDTH: combinational value that `Q` takes at the next rising edge.

## Operation

- Reset has priority. If `RST_N`=0, then `Q_next` = 0 and `Q` becomes 0 at the edge, regardless of `sh` or `D`.
- Load (`RST_N`=1, `sh`=0): `Q_next` = `D`.
- Shift (`RST_N`=1, `sh`=1): `Q_next` = {`Q`[WIDTH-2:0], 1'b0}. This is a logical left shift with zero fill, and the MSB is discarded.
- On every rising edge, `Q` <= `Q_next`. There is no hold mode, so the register updates every cycle.
- `D` is ignored in shift mode.
- Outputs are fully defined at all times; no X propagation is permitted from `sh`/`D` once they are driven.

## Timing

- `Q` has a latency of 1 cycle from `D`/`sh`/`RST_N` sampled at a rising edge.
- `Q_next` is purely combinational from `RST_N`, `sh`, `D` and `Q`, with zero cycle latency. It changes immediately when inputs change, including between edges.
- Reset value of `Q` is 0. `Q_next` reads 0 whenever `RST_N`=0.
- Before the first reset edge, `Q` is undefined. The bench must apply reset for at least 1 edge.
- Reset asserted mid-shift sequence: `Q` is 0 at that edge. The first edge after deassertion loads or shifts from 0.
- Boundary: after WIDTH consecutive shifts with no load, `Q` = 0 (non-rotate build).
- Changing `sh` between edges: only the value present at the rising edge matters for `Q`, while `Q_next` tracks it continuously.

## Configuration

- Macro: `REGISTERS_ROTATE_EN`.
- Defined: shift mode is a left rotate, `Q_next` = {`Q`[WIDTH-2:0], `Q`[WIDTH-1]}. The MSB wraps to the LSB and the contents never drain to zero by shifting.
- Not defined: shift mode is a zero-fill logical left shift, as specified above.
- Load and reset behaviour are identical in both builds.

## Test plan

- Reset: `RST_N`=0 for 2 edges with `D`=4'hF and `sh`=0 gives `Q`=0 and `Q_next`=0. Then `RST_N`=1 with `D`=4'h5 gives `Q_next`=5 immediately and `Q`=5 after the next edge.
- Load sweep: `sh`=0 and `D` incrementing 0..F, holding each value for 2 edges, gives `Q` equal to `D` one edge later each time, and `Q_next` equal to `D` combinationally.
- Shift drain (default build): load 4'h5, then `sh`=1 for 4 edges, gives `Q` = A, 4, 8, 0. At `Q`=8, `Q_next` reads 0.
- Rotate (`REGISTERS_ROTATE_EN`): load 4'h9, then `sh`=1 for 4 edges, gives `Q` = 3, 6, C, 9.
- Reset mid-shift: load 4'hF, shift once (`Q`=E), then `RST_N`=0 with `sh`=1 for one edge, gives `Q`=0. Release reset and shift once more to get `Q`=0. Then load 4'h1 to get `Q`=1.
- Mode toggle between edges: with `Q`=3 and `D`=C, toggle `sh` 0 to 1 mid-cycle. `Q_next` must go C to 6 without a clock edge, and `Q` must stay 3 until the edge.

Source files
------------

// File: rtl/registers.sv
// registers: parameterised parallel-load / shift storage element for the MIPS datapath.
// Each rising edge of CLK either captures D (sh=0) or shifts Q left by one (sh=1).
// Q_next exports, combinationally, the value Q will take at the next rising edge.
// Optional build macro: REGISTERS_ROTATE_EN
//   undefined (default): shift is a zero-fill logical left shift, MSB discarded
//   defined            : shift is a left rotate, MSB wraps into the LSB
// Reset is synchronous and active-low; it forces Q_next to zero and has priority.
module registers #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  input  logic             sh,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_next
);

  // Shift-by-one of the stored word; the fill bit depends on the build.
  function automatic logic [WIDTH-1:0] shift_left(input logic [WIDTH-1:0] value);
    logic fill_bit;
`ifdef REGISTERS_ROTATE_EN
    fill_bit = value[WIDTH-1];
`else
    fill_bit = 1'b0;
`endif
    return {value[WIDTH-2:0], fill_bit};
  endfunction

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state selection: reset first, then shift or parallel load.
  always_comb begin
    q_d = '0;
    if (!RST_N) begin
      q_d = '0;
    end else if (sh) begin
      q_d = shift_left(q_q);
    end else begin
      q_d = D;
    end
  end

  // State register: synchronous active-low reset, otherwise update every edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q      = q_q;
  assign Q_next = q_d;

endmodule

// File: tb/tb_registers.sv
// tb_registers: directed self-checking bench for registers (WIDTH=4).
// A behavioural model tracks the expected contents arithmetically and a compare
// process checks Q and Q_next against it on every falling edge; directed steps
// also check hand-computed literal values.
module tb_registers;

  localparam int W = 4;

  logic         CLK;
  logic         RST_N;
  logic [W-1:0] D;
  logic         sh;
  logic [W-1:0] Q;
  logic [W-1:0] Q_next;

  int tests_run;
  int tests_failed;

  int model_q;
  bit model_valid;

  registers #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (D),
    .sh    (sh),
    .Q     (Q),
    .Q_next(Q_next)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected next contents, computed as arithmetic on integers.
  function automatic int model_next(input logic r, input logic s, input int d, input int q);
    int v;
    if (r !== 1'b1) return 0;
    if (s !== 1'b1) return d;
    v = q * 2;
`ifdef REGISTERS_ROTATE_EN
    v = v + (q / (2 ** (W - 1)));
`endif
    return v % (2 ** W);
  endfunction

  // Model register: advances on every rising edge from the sampled inputs.
  always @(posedge CLK) begin
    model_q     = model_next(RST_N, sh, int'(D), model_q);
    model_valid = 1'b1;
  end

  task automatic check(input string name, input logic [W-1:0] actual, input int expected);
    tests_run++;
    if (actual !== W'(expected)) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, W'(expected), $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (model_valid) begin
      check("model_Q", Q, model_q);
      check("model_Q_next", Q_next, model_next(RST_N, sh, int'(D), model_q));
    end
  end

  task automatic drive(input logic r, input logic s, input logic [W-1:0] d);
    RST_N = r;
    sh    = s;
    D     = d;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [W-1:0] shift_exp [4];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_q      = 0;
    model_valid  = 1'b0;

    // Reset for two edges with D=F, sh=0.
    drive(1'b0, 1'b0, 4'hF);
    tick();
    tick();
    check("reset_Q", Q, 0);
    check("reset_Q_next", Q_next, 0);
    drive(1'b1, 1'b0, 4'h5);
    #1;
    check("post_reset_Q_next", Q_next, 5);
    check("post_reset_Q_hold", Q, 0);
    tick();
    check("post_reset_Q", Q, 5);

    // Load sweep, each value held for two edges.
    for (int d = 0; d < 16; d++) begin
      drive(1'b1, 1'b0, W'(d));
      #1;
      check("load_Q_next", Q_next, d);
      tick();
      check("load_Q_first", Q, d);
      tick();
      check("load_Q_second", Q, d);
    end

    // Shift sequence; D held at F to show it is ignored in shift mode.
`ifdef REGISTERS_ROTATE_EN
    drive(1'b1, 1'b0, 4'h9);
    shift_exp[0] = 4'h3; shift_exp[1] = 4'h6; shift_exp[2] = 4'hC; shift_exp[3] = 4'h9;
`else
    drive(1'b1, 1'b0, 4'h5);
    shift_exp[0] = 4'hA; shift_exp[1] = 4'h4; shift_exp[2] = 4'h8; shift_exp[3] = 4'h0;
`endif
    tick();
    drive(1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("shift_Q", Q, int'(shift_exp[i]));
`ifndef REGISTERS_ROTATE_EN
      if (i == 2) check("drain_Q_next", Q_next, 0);
`endif
    end

    // Reset asserted in the middle of a shift sequence.
    drive(1'b1, 1'b0, 4'hF);
    tick();
    check("midrst_load", Q, 15);
    drive(1'b1, 1'b1, 4'hF);
    tick();
    check("midrst_shift1", Q, 14);
    drive(1'b0, 1'b1, 4'hF);
    #1;
    check("midrst_Q_next", Q_next, 0);
    tick();
    check("midrst_Q", Q, 0);
    drive(1'b1, 1'b1, 4'hF);
    tick();
    check("midrst_shift_zero", Q, 0);
    drive(1'b1, 1'b0, 4'h1);
    tick();
    check("midrst_reload", Q, 1);

    // Mode toggle between edges.
    drive(1'b1, 1'b0, 4'h3);
    tick();
    check("toggle_Q_init", Q, 3);
    drive(1'b1, 1'b0, 4'hC);
    #1;
    check("toggle_Q_next_load", Q_next, 12);
    #5;
    sh = 1'b1;
    #1;
    check("toggle_Q_next_shift", Q_next, 6);
    check("toggle_Q_hold", Q, 3);
    tick();
    check("toggle_Q_after", Q, 6);

    @(negedge CLK);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
